// File: rtl/serial_tx.sv
// serial_tx: UART 8N1 transmitter with byte FIFO and CTS flow control
module serial_tx #(
  parameter int CLK_HZ = 74250000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input  logic clk74,
  input  logic reset_n,
  input  logic [7:0] tx_byte,
  input  logic tx_wr,
  input  logic cts_n,
  output logic tx,
  output logic tx_full,
  output logic tx_empty,
  output logic tx_busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic overflow
);
  localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DIVISOR - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_n;
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic tx_n, cts_s1, cts_s2, cts_ok, wr_ok, pop, tick;
  always_comb begin
    cts_ok = ~cts_s2;
    tick = cnt == '0;
    wr_ok = tx_wr && fifo_level != FULL;
    // a frame may start from IDLE or straight out of a finished stop bit
    pop = (state == IDLE || (state == STOP && tick)) && fifo_level != '0 && cts_ok;
    level_n = fifo_level + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
    cnt_n = (state == IDLE && !pop) ? '0 : (pop || tick) ? CNT_TOP : cnt - 1'b1;
    state_n = state;
    bit_idx_n = bit_idx;
    shift_n = shift;
    tx_n = tx;
    if (pop) begin
      state_n = START;
      shift_n = mem[rd_ptr];
      tx_n = 1'b0;
    end else if (tick) begin
      case (state)
        START: begin
          state_n = DATA;
          bit_idx_n = 3'd0;
          tx_n = shift[0];
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n = 1'b1;
          end else begin
            shift_n = shift >> 1;
            tx_n = shift[1];
            bit_idx_n = bit_idx + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          tx_n = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk74 or negedge reset_n) begin
    if (!reset_n) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
      tx_full <= 1'b0;
      tx_empty <= 1'b1;
      tx_busy <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      cts_s1 <= cts_n;
      cts_s2 <= cts_s1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_n;
      overflow <= overflow | (tx_wr && fifo_level == FULL);
      tx_full <= level_n == FULL;
      tx_empty <= level_n == '0;
      tx_busy <= state_n != IDLE;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      tx <= tx_n;
    end
  end
  always_ff @(posedge clk74) begin
    if (wr_ok) mem[wr_ptr] <= tx_byte;
  end
endmodule
